// File: rtl/m5_ps2_keymatrix_pkg.sv
// m5_kbd_pkg: types and constants for the PS/2-to-keyboard-matrix bridge.
//   row_t / col_t : matrix coordinates (7 rows x 8 columns)
//   key_t         : lookup key {extended, set-2 scancode}
//   map_t         : keymap result {hit, row, col, nmi}
//   nmi_state_t   : reset-key pulse generator states
package m5_kbd_pkg;

    localparam int unsigned NROWS = 7;

    typedef logic [2:0] row_t;
    typedef logic [2:0] col_t;
    typedef logic [8:0] key_t;

    // F12, non-extended: drives the reset-key NMI instead of the matrix
    localparam key_t NMI_KEY = 9'h007;

    typedef struct packed {
        logic hit;
        row_t row;
        col_t col;
        logic nmi;
    } map_t;

    typedef enum logic {
        NMI_IDLE,
        NMI_PULSE
    } nmi_state_t;

    function automatic map_t key_at(row_t r, col_t c);
        map_t m;
        m.hit = 1'b1;
        m.row = r;
        m.col = c;
        m.nmi = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/m5_ps2_keymatrix_if.sv
// Console-side bus of the keyboard matrix bridge.
//   ps2_key_i  : HPS key event [10] toggle, [9] pressed, [8] extended, [7:0] code
//   clear_i    : release-all request, level-sensitive
//   row_sel_i  : row address from I/O decode (rows 0-6, 7 reads as empty)
//   row_data_o : pressed-key bits of the selected row, active-high
//   any_key_o  : any matrix bit set
//   nmi_o      : reset-key NMI pulse
// master = driver of the inputs (HPS/console side), slave = the bridge.
interface m5_ps2_keymatrix_if;

    logic [10:0] ps2_key_i;
    logic        clear_i;
    logic [2:0]  row_sel_i;
    logic [7:0]  row_data_o;
    logic        any_key_o;
    logic        nmi_o;

    modport master (
        output ps2_key_i, clear_i, row_sel_i,
        input  row_data_o, any_key_o, nmi_o
    );

    modport slave (
        input  ps2_key_i, clear_i, row_sel_i,
        output row_data_o, any_key_o, nmi_o
    );

endinterface

// File: rtl/m5_ps2_keymatrix_keymap.sv
// m5_keymap: combinational set-2 scancode table.
//   key_i : {extended, scancode}
//   map_o : {hit, row, col, nmi}; unmapped keys return all zero,
//           F12 returns nmi=1 with hit=0 so it never reaches the matrix.
module m5_keymap
    import m5_kbd_pkg::*;
(
    input  key_t key_i,
    output map_t map_o
);

    always_comb begin
        map_o = '0;
        case (key_i)
            // row 0: modifiers and wide keys
            9'h014: map_o = key_at(3'd0, 3'd0); // L-Ctrl
            9'h00D: map_o = key_at(3'd0, 3'd1); // Tab
            9'h012: map_o = key_at(3'd0, 3'd2); // L-Shift
            9'h059: map_o = key_at(3'd0, 3'd3); // R-Shift
            9'h058: map_o = key_at(3'd0, 3'd4); // Caps Lock
            9'h114: map_o = key_at(3'd0, 3'd5); // R-Ctrl
            9'h029: map_o = key_at(3'd0, 3'd6); // Space
            9'h05A: map_o = key_at(3'd0, 3'd7); // Enter
            // row 1: 1..8
            9'h016: map_o = key_at(3'd1, 3'd0);
            9'h01E: map_o = key_at(3'd1, 3'd1);
            9'h026: map_o = key_at(3'd1, 3'd2);
            9'h025: map_o = key_at(3'd1, 3'd3);
            9'h02E: map_o = key_at(3'd1, 3'd4);
            9'h036: map_o = key_at(3'd1, 3'd5);
            9'h03D: map_o = key_at(3'd1, 3'd6);
            9'h03E: map_o = key_at(3'd1, 3'd7);
            // row 2: A S D F G H J K
            9'h01C: map_o = key_at(3'd2, 3'd0);
            9'h01B: map_o = key_at(3'd2, 3'd1);
            9'h023: map_o = key_at(3'd2, 3'd2);
            9'h02B: map_o = key_at(3'd2, 3'd3);
            9'h034: map_o = key_at(3'd2, 3'd4);
            9'h033: map_o = key_at(3'd2, 3'd5);
            9'h03B: map_o = key_at(3'd2, 3'd6);
            9'h042: map_o = key_at(3'd2, 3'd7);
            // row 3: Q W E R T Y U I
            9'h015: map_o = key_at(3'd3, 3'd0);
            9'h01D: map_o = key_at(3'd3, 3'd1);
            9'h024: map_o = key_at(3'd3, 3'd2);
            9'h02D: map_o = key_at(3'd3, 3'd3);
            9'h02C: map_o = key_at(3'd3, 3'd4);
            9'h035: map_o = key_at(3'd3, 3'd5);
            9'h03C: map_o = key_at(3'd3, 3'd6);
            9'h043: map_o = key_at(3'd3, 3'd7);
            // row 4: Z X C V B N M ,
            9'h01A: map_o = key_at(3'd4, 3'd0);
            9'h022: map_o = key_at(3'd4, 3'd1);
            9'h021: map_o = key_at(3'd4, 3'd2);
            9'h02A: map_o = key_at(3'd4, 3'd3);
            9'h032: map_o = key_at(3'd4, 3'd4);
            9'h031: map_o = key_at(3'd4, 3'd5);
            9'h03A: map_o = key_at(3'd4, 3'd6);
            9'h041: map_o = key_at(3'd4, 3'd7);
            // row 5: 9 0 - = O P [ ]
            9'h046: map_o = key_at(3'd5, 3'd0);
            9'h045: map_o = key_at(3'd5, 3'd1);
            9'h04E: map_o = key_at(3'd5, 3'd2);
            9'h055: map_o = key_at(3'd5, 3'd3);
            9'h044: map_o = key_at(3'd5, 3'd4);
            9'h04D: map_o = key_at(3'd5, 3'd5);
            9'h054: map_o = key_at(3'd5, 3'd6);
            9'h05B: map_o = key_at(3'd5, 3'd7);
            // row 6: L ; ' . / \ Backspace Esc
            9'h04B: map_o = key_at(3'd6, 3'd0);
            9'h04C: map_o = key_at(3'd6, 3'd1);
            9'h052: map_o = key_at(3'd6, 3'd2);
            9'h049: map_o = key_at(3'd6, 3'd3);
            9'h04A: map_o = key_at(3'd6, 3'd4);
            9'h05D: map_o = key_at(3'd6, 3'd5);
            9'h066: map_o = key_at(3'd6, 3'd6);
            9'h076: map_o = key_at(3'd6, 3'd7);
            NMI_KEY: map_o.nmi = 1'b1;
            default: map_o = '0;
        endcase
    end

endmodule

// File: rtl/m5_ps2_keymatrix.sv
// m5_ps2_keymatrix: turns HPS PS/2 key events into a 7x8 console key matrix
// and a reset-key NMI pulse.
//   clk_i   : system clock (single clock domain)
//   reset_i : synchronous, active-high
//   kb      : console bus (slave side), see m5_ps2_keymatrix_if
// Pipeline per event: E0 capture/detect, E0+1 lookup registered,
// E0+2 matrix/NMI update, E0+3 row_data_o/any_key_o registered.
module m5_ps2_keymatrix
    import m5_kbd_pkg::*;
#(
    parameter int unsigned NMI_LEN = 64
)(
    input  logic                 clk_i,
    input  logic                 reset_i,
    m5_ps2_keymatrix_if.slave    kb
);

    // stage 0: toggle tracking and event capture
    logic       tog_q;
    logic       v1;
    logic [9:0] key1;

    // stage 1: registered lookup
    map_t       map1;
    map_t       map2;
    logic       v2;
    logic       pressed2;

    // matrix and read side
    logic [NROWS-1:0][7:0] matrix;
    logic [7:0]            sel_row;

    // reset-key pulse
    nmi_state_t st, st_n;
    logic [7:0] cnt, cnt_n;
    logic       nmi_start;

    // The toggle keeps following the input during reset so that the first
    // edge after reset compares against the current level, not a stale one.
    always_ff @(posedge clk_i) begin
        tog_q <= kb.ps2_key_i[10];
        key1  <= kb.ps2_key_i[9:0];
        if (reset_i)
            v1 <= 1'b0;
        else
            v1 <= (kb.ps2_key_i[10] != tog_q);
    end

    m5_keymap u_keymap (
        .key_i (key1[8:0]),
        .map_o (map1)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i)
            v2 <= 1'b0;
        else
            v2 <= v1;
        map2     <= map1;
        pressed2 <= key1[9];
    end

    // clear_i has priority so a coincident update is dropped, not merged
    always_ff @(posedge clk_i) begin
        if (reset_i || kb.clear_i)
            matrix <= '0;
        else if (v2 && map2.hit && (map2.row < 3'(NROWS)))
            matrix[map2.row][map2.col] <= pressed2;
    end

    always_comb begin
        sel_row = '0;
        for (int unsigned r = 0; r < NROWS; r++) begin
            if (kb.row_sel_i == 3'(r))
                sel_row = matrix[r];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            kb.row_data_o <= '0;
            kb.any_key_o  <= 1'b0;
        end else begin
            kb.row_data_o <= sel_row;
            kb.any_key_o  <= |matrix;
        end
    end

    // Only F12 presses start the pulse; releases and presses during an
    // active pulse are ignored (IDLE is the only state that accepts a start).
    assign nmi_start = v2 && map2.nmi && pressed2 && !kb.clear_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st  <= NMI_IDLE;
            cnt <= '0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
        end
    end

    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        case (st)
            NMI_IDLE: begin
                if (nmi_start) begin
                    st_n  = NMI_PULSE;
                    cnt_n = 8'(NMI_LEN - 1);
                end
            end
            NMI_PULSE: begin
                if (cnt == '0)
                    st_n = NMI_IDLE;
                else
                    cnt_n = cnt - 8'd1;
            end
            default: st_n = NMI_IDLE;
        endcase
    end

    always_comb begin
        kb.nmi_o = (st == NMI_PULSE);
    end

endmodule

// File: tb/tb_m5_ps2_keymatrix.sv
module tb_m5_ps2_keymatrix;

    logic clk;
    logic reset;
    logic tog;
    int   total;
    int   bad;
    int   n;
    logic resent;

    m5_ps2_keymatrix_if kb ();

    m5_ps2_keymatrix #(.NMI_LEN(64)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .kb      (kb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        tog = ~tog;
        kb.ps2_key_i = {tog, pressed, ext, code};
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tog   = 1'b0;
        resent = 1'b0;
        reset = 1'b1;
        kb.ps2_key_i = '0;
        kb.clear_i   = 1'b0;
        kb.row_sel_i = 3'd0;

        // reset state
        tick(3);
        check("rst_row",  {24'd0, kb.row_data_o}, 32'h00);
        check("rst_any",  {31'd0, kb.any_key_o},  32'd0);
        check("rst_nmi",  {31'd0, kb.nmi_o},      32'd0);
        reset = 1'b0;
        tick(1);

        // 'A' press: visible exactly on the 4th edge
        kb.row_sel_i = 3'd2;
        send(1'b1, 1'b0, 8'h1C);
        tick(3);
        check("a_lat3_row", {24'd0, kb.row_data_o}, 32'h00);
        check("a_lat3_any", {31'd0, kb.any_key_o},  32'd0);
        tick(1);
        check("a_lat4_row", {24'd0, kb.row_data_o}, 32'h01);
        check("a_lat4_any", {31'd0, kb.any_key_o},  32'd1);
        send(1'b0, 1'b0, 8'h1C);
        tick(4);
        check("a_rel_row", {24'd0, kb.row_data_o}, 32'h00);

        // L-Shift + Space on row 0
        kb.row_sel_i = 3'd0;
        send(1'b1, 1'b0, 8'h12);
        tick(1);
        send(1'b1, 1'b0, 8'h29);
        tick(4);
        check("shsp_row", {24'd0, kb.row_data_o}, 32'h44);
        send(1'b0, 1'b0, 8'h12);
        tick(4);
        check("sp_only_row", {24'd0, kb.row_data_o}, 32'h40);
        send(1'b0, 1'b0, 8'h29);
        tick(4);
        check("none_row", {24'd0, kb.row_data_o}, 32'h00);
        check("none_any", {31'd0, kb.any_key_o},  32'd0);

        // F12 pulse, re-press 10 cycles in must not extend it
        send(1'b1, 1'b0, 8'h07);
        tick(2);
        check("nmi_e1", {31'd0, kb.nmi_o}, 32'd0);
        tick(1);
        check("nmi_e2", {31'd0, kb.nmi_o}, 32'd1);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            if (n == 10 && !resent) begin
                send(1'b1, 1'b0, 8'h07);
                resent = 1'b1;
            end
            tick(1);
            if (kb.nmi_o)
                n++;
            else
                break;
        end
        check("nmi_len", n, 32'd64);
        check("nmi_mat_any", {31'd0, kb.any_key_o},  32'd0);
        check("nmi_mat_row", {24'd0, kb.row_data_o}, 32'h00);
        send(1'b0, 1'b0, 8'h07);
        tick(6);
        check("nmi_rel_ign", {31'd0, kb.nmi_o}, 32'd0);

        // clear coincident with Enter reaching the update stage
        kb.row_sel_i = 3'd2;
        send(1'b1, 1'b0, 8'h1C);
        tick(4);
        check("hold_a", {24'd0, kb.row_data_o}, 32'h01);
        send(1'b1, 1'b0, 8'h5A);
        tick(2);
        kb.clear_i = 1'b1;
        tick(1);
        kb.clear_i = 1'b0;
        tick(1);
        check("clr_row2", {24'd0, kb.row_data_o}, 32'h00);
        kb.row_sel_i = 3'd0;
        tick(1);
        check("clr_row0", {24'd0, kb.row_data_o}, 32'h00);
        check("clr_any",  {31'd0, kb.any_key_o},  32'd0);
        send(1'b1, 1'b0, 8'h5A);
        tick(4);
        check("enter_row0", {24'd0, kb.row_data_o}, 32'h80);
        send(1'b0, 1'b0, 8'h5A);
        tick(4);
        check("enter_rel_any", {31'd0, kb.any_key_o}, 32'd0);

        // toggle held high through reset: no spurious 'A' press
        reset = 1'b1;
        tog = 1'b1;
        kb.ps2_key_i = {1'b1, 1'b1, 1'b0, 8'h1C};
        tick(2);
        reset = 1'b0;
        kb.row_sel_i = 3'd2;
        tick(5);
        check("rst_tog_row2", {24'd0, kb.row_data_o}, 32'h00);
        check("rst_tog_any",  {31'd0, kb.any_key_o},  32'd0);
        send(1'b1, 1'b0, 8'h7E);
        tick(4);
        check("unmapped_any", {31'd0, kb.any_key_o}, 32'd0);
        send(1'b1, 1'b0, 8'h5A);
        tick(4);
        kb.row_sel_i = 3'd7;
        tick(1);
        check("row7_row", {24'd0, kb.row_data_o}, 32'h00);
        check("row7_any", {31'd0, kb.any_key_o},  32'd1);
        send(1'b0, 1'b0, 8'h5A);
        tick(4);

        // back-to-back events: '1' then 'A'
        kb.row_sel_i = 3'd1;
        send(1'b1, 1'b0, 8'h16);
        tick(1);
        send(1'b1, 1'b0, 8'h1C);
        tick(4);
        check("b2b_row1", {24'd0, kb.row_data_o}, 32'h01);
        kb.row_sel_i = 3'd2;
        tick(1);
        check("b2b_row2", {24'd0, kb.row_data_o}, 32'h01);

        // reset one cycle after a third event (Space): event lost
        send(1'b1, 1'b0, 8'h29);
        tick(1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        kb.row_sel_i = 3'd0;
        tick(5);
        check("rstmid_row0", {24'd0, kb.row_data_o}, 32'h00);
        check("rstmid_any",  {31'd0, kb.any_key_o},  32'd0);
        check("rstmid_nmi",  {31'd0, kb.nmi_o},      32'd0);

        // reset mid-pulse ends the pulse on the next edge
        send(1'b1, 1'b0, 8'h07);
        tick(3);
        check("pulse_on", {31'd0, kb.nmi_o}, 32'd1);
        reset = 1'b1;
        tick(1);
        check("pulse_rst", {31'd0, kb.nmi_o}, 32'd0);
        reset = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m5_ps2_keymatrix.md
M5_PS2_KEYMATRIX -- requirements
Module: m5_ps2_keymatrix

Interface
REQ-001 Parameter NMI_LEN, default 64, sets the width of the reset-key pulse in clk_i cycles (range 2..255).
REQ-002 clk_i  in  1  system clock; the block SHALL use this one clock only.
REQ-003 reset_i  in  1  reset, synchronous and active-high.
REQ-004 ps2_key_i  in  11  key event from the HPS interface: [10] toggle strobe, [9] pressed, [8] extended, [7:0] set-2 scancode.
REQ-005 clear_i  in  1  release-all request (OSD open or download), level-sensitive.
REQ-006 row_sel_i  in  3  keyboard row address from the console I/O decode (ports 30h-36h map to rows 0-6).
REQ-007 row_data_o  out  8  pressed-key bits of the selected row, active-high.
REQ-008 any_key_o  out  1  high while any matrix bit is set.
REQ-009 nmi_o  out  1  reset-key NMI request pulse, active-high.

Function
REQ-010 The block SHALL treat every change of ps2_key_i[10] relative to the last captured toggle value as exactly one event.
REQ-011 Pipeline: edge E0 captures ps2_key_i and detects the event; edge E0+1 registers the lookup result {hit,row,col,nmi}; edge E0+2 updates the 7x8 matrix; edge E0+3 updates row_data_o.
REQ-012 Lookup key = {extended, scancode}; a miss SHALL leave the matrix unchanged.
REQ-013 Hit with pressed=1 SHALL set matrix[row][col]; pressed=0 SHALL clear it; other bits SHALL be unaffected.
REQ-014 Repeated press events for a held key SHALL be idempotent.
REQ-015 row_data_o SHALL be registered as matrix[row_sel_i] each cycle; row_sel_i=7 SHALL yield 8'h00.
REQ-016 any_key_o SHALL be registered as the OR-reduction of the matrix, with the same timing as row_data_o.
REQ-017 Key F12 ({0,8'h07}) SHALL NOT enter the matrix; its press SHALL start an nmi_o pulse at edge E0+2 lasting exactly NMI_LEN cycles; its release SHALL be ignored.
REQ-018 An F12 press while the pulse is active SHALL be ignored; the pulse SHALL neither restart nor extend.
REQ-019 While clear_i=1 the matrix SHALL be all zero, and any event reaching the update stage SHALL be discarded; clear_i SHALL win over a simultaneous update.
REQ-020 clear_i SHALL NOT abort an active nmi_o pulse and SHALL NOT suppress toggle tracking.
REQ-021 Toggle events on consecutive cycles SHALL each be processed in order with no loss (the pipeline accepts one event per cycle).

Reset
REQ-022 While reset_i=1: matrix=0, row_data_o=8'h00, any_key_o=0, nmi_o=0, pulse counter=0, pipeline valid bits=0.
REQ-023 While reset_i=1 the captured toggle SHALL track ps2_key_i[10], so that release of reset produces no spurious event.
REQ-024 Reset asserted mid-pipeline or mid-pulse SHALL discard the in-flight event and terminate the pulse on the next edge.

Structure
REQ-025 Package m5_kbd_pkg SHALL hold the row/col typedefs, the NMI scancode constant and the number of rows (7).
REQ-026 The scancode table SHALL be a sub-module m5_keymap, combinational, mapping {ext,code} to {hit,row[2:0],col[2:0],nmi}.
REQ-027 Normative table entries: L-Ctrl 14h->r0b0; L-Shift 12h->r0b2; R-Shift 59h->r0b3; Space 29h->r0b6; Enter 5Ah->r0b7; 'A' 1Ch->r2b0; '1' 16h->r1b0; unmapped codes (e.g. 7Eh) miss.
REQ-028 Synthesis target: no RAM inference; the matrix is a set of flops.

Verification
REQ-029 Reset, then toggle with 'A' pressed, row_sel_i=2 -> row_data_o=8'h01 and any_key_o=1 exactly 4 edges after the ps2_key_i change.
REQ-030 Press L-Shift then Space, row_sel_i=0 -> 8'h44; release L-Shift -> 8'h40; release Space -> 8'h00, any_key_o=0.
REQ-031 Press F12 with NMI_LEN=64 -> nmi_o high for exactly 64 cycles; a second F12 press 10 cycles in -> the pulse still ends at cycle 64; matrix unchanged.
REQ-032 Hold 'A', assert clear_i for 1 cycle coincident with an Enter press reaching the update stage -> all rows 8'h00, Enter absent; the next Enter press sets r0b7.
REQ-033 Hold ps2_key_i[10]=1 through reset, release reset -> no event; unmapped 7Eh press -> no matrix change; row_sel_i=7 -> 8'h00.
REQ-034 Two toggle events on consecutive cycles ('1' press, 'A' press) -> both r1b0 and r2b0 set; reset asserted one cycle after a third event -> that event lost, all outputs zero.
